// File: rtl/tbec_rsc_decoder13_if.sv
// tbec_rsc_decoder13_if: codeword-in / result-out handshake bundle for the decoder.
//   in_valid, codeword_in[0:31] : producer offers a codeword (bit 0 is the MSB)
//   in_ready                    : decoder can accept a codeword
//   out_valid, data_out[0:15]   : corrected data word, bit 0 is the MSB
//   status[1:0]                 : 00 clean, 01 corrected, 10 check-only error, 11 uncorrectable
//   out_ready                   : consumer takes the result
interface tbec_rsc_decoder13_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [0:15] data_out;
    logic [1:0]  status;

    modport master (
        output in_valid, codeword_in, out_ready,
        input  in_ready, out_valid, data_out, status
    );

    modport slave (
        input  in_valid, codeword_in, out_ready,
        output in_ready, out_valid, data_out, status
    );
endinterface

// File: rtl/tbec_rsc_decoder13.sv
// tbec_rsc_decoder13: 4x4 product-code decoder (row, group and diagonal parity) with error counters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   io (slave)           : codeword in / corrected data and status out handshake
//   cnt_clr              : synchronous clear of both counters
//   corr_cnt, uncorr_cnt : saturating counts of corrected / uncorrectable results
module tbec_rsc_decoder13 (
    input  logic                 clk,
    input  logic                 rst_n,
    tbec_rsc_decoder13_if.slave  io,
    input  logic                 cnt_clr,
    output logic [15:0]          corr_cnt,
    output logic [15:0]          uncorr_cnt
);
    typedef enum logic [2:0] {IDLE, SYND, CORR, CHECK, DONE} state_t;

    state_t      state, state_nx;
    logic [0:31] cw;
    logic [15:0] syn;
    logic [0:15] fixed;
    logic        flipped;
    logic [0:15] dout;
    logic [1:0]  stat, stat_nx;
    logic [0:15] raw, mask;
    logic [15:0] rx, residual;

    // Check vectors are kept internally as {cb[7:0], p[3:0], di[3:0]} with cb index 2*b+k.
    // Data words are row-major: d[4*b+j] = s[b][j].
    function automatic logic [15:0] checks(input logic [0:15] d);
        logic [7:0] cb;
        logic [3:0] p, di;
        cb = '0;
        p  = '0;
        di = '0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) begin
                cb[2*b+(j%2)]             ^= d[4*b+j];
                p[b/2+2*(j/2)]            ^= d[4*b+j];
                di[2*(j/2)+((j%2)^(b%2))] ^= d[4*b+j];
            end
        end
        return {cb, p, di};
    endfunction

    // Received check bits reordered from the on-wire layout into the internal order.
    function automatic logic [15:0] rx_checks(input logic [0:31] c);
        logic [7:0] cb;
        for (int i = 0; i < 8; i++) cb[i] = c[24+i];
        return {cb, c[21], c[23], c[22], c[20], c[17], c[19], c[18], c[16]};
    endfunction

    // The codeword carries the data column-major; undo the transpose.
    function automatic logic [0:15] extract(input logic [0:31] c);
        logic [0:15] d;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) d[4*b+j] = c[4*j+b];
        end
        return d;
    endfunction

    always_comb begin
        raw  = extract(cw);
        rx   = rx_checks(cw);
        mask = '0;
        // A bit is flipped only when its row, group and diagonal syndromes all fire.
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) begin
                mask[4*b+j] = syn[8+2*b+(j%2)] & syn[4+b/2+2*(j/2)] & syn[2*(j/2)+((j%2)^(b%2))];
            end
        end
        residual = rx ^ checks(fixed);
        stat_nx  = (syn == '0) ? 2'b00 : !flipped ? 2'b10 : (residual == '0) ? 2'b01 : 2'b11;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = io.in_valid ? SYND : IDLE;
            SYND:    state_nx = CORR;
            CORR:    state_nx = CHECK;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = io.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw      <= '0;
            syn     <= '0;
            fixed   <= '0;
            flipped <= 1'b0;
            dout    <= '0;
            stat    <= 2'b00;
        end else begin
            if (state == IDLE && io.in_valid) cw <= io.codeword_in;
            if (state == SYND) syn <= rx ^ checks(raw);
            if (state == CORR) begin
                fixed   <= raw ^ mask;
                flipped <= |mask;
            end
            if (state == CHECK) begin
                dout <= fixed;
                stat <= stat_nx;
            end
        end
    end

    // Counters update on the CHECK->DONE edge using the status being registered there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (state == CHECK) begin
            if (stat_nx == 2'b01 && corr_cnt != 16'hFFFF)   corr_cnt   <= corr_cnt + 16'd1;
            if (stat_nx == 2'b11 && uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.data_out  = dout;
    assign io.status    = stat;
endmodule

// File: tb/tb_tbec_rsc_decoder13.sv
// tb_tbec_rsc_decoder13: directed and randomized checks of the decoder against an equation-level model.
module tb_tbec_rsc_decoder13;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] corr_cnt, uncorr_cnt;
    int          tests = 0;
    int          fails = 0;
    int          exp_corr = 0;
    int          exp_uncorr = 0;

    always #5 clk = ~clk;

    tbec_rsc_decoder13_if io();

    tbec_rsc_decoder13 dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io.slave),
        .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    // Check bits in on-wire order (Di0,Di3,Di1,Di2,P0,P3,P1,P2,Cb00..Cb31) from row-major data d[4b+j].
    function automatic logic [0:15] enc(input logic [0:15] d);
        logic [0:15] r;
        r[0] = d[0] ^ d[5] ^ d[8]  ^ d[13];
        r[2] = d[1] ^ d[4] ^ d[9]  ^ d[12];
        r[3] = d[2] ^ d[7] ^ d[10] ^ d[15];
        r[1] = d[3] ^ d[6] ^ d[11] ^ d[14];
        r[4] = d[0] ^ d[1] ^ d[4]  ^ d[5];
        r[6] = d[8] ^ d[9] ^ d[12] ^ d[13];
        r[7] = d[2] ^ d[3] ^ d[6]  ^ d[7];
        r[5] = d[10] ^ d[11] ^ d[14] ^ d[15];
        for (int b = 0; b < 4; b++) begin
            r[8+2*b] = d[4*b]   ^ d[4*b+2];
            r[9+2*b] = d[4*b+1] ^ d[4*b+3];
        end
        return r;
    endfunction

    function automatic logic [0:15] data_of(input logic [0:31] c);
        logic [0:15] r;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++) r[4*b+j] = c[4*j+b];
        return r;
    endfunction

    function automatic logic [0:31] build(input logic [0:15] d);
        logic [0:31] r;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++) r[4*j+b] = d[4*b+j];
        r[16:31] = enc(d);
        return r;
    endfunction

    // A data bit is corrected when every check it participates in reports an error.
    function automatic void model(input logic [0:31] c, output logic [0:15] dout, output logic [1:0] st);
        logic [0:15] d, rx, syn, mask, oh, t, res;
        d    = data_of(c);
        rx   = c[16:31];
        syn  = rx ^ enc(d);
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            oh    = '0;
            oh[i] = 1'b1;
            t     = enc(oh);
            mask[i] = ((syn & t) == t);
        end
        dout = d ^ mask;
        res  = rx ^ enc(dout);
        st   = (syn == '0) ? 2'b00 : (mask == '0) ? 2'b10 : (res == '0) ? 2'b01 : 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, latency, result, counters, and return to idle if out_ready is high.
    task automatic send(input logic [0:31] c, input string tag);
        logic [0:15] ed;
        logic [1:0]  es;
        int          n;
        model(c, ed, es);
        n = 0;
        while (io.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, {31'd0, io.in_ready}, 32'd1);
        io.codeword_in = c;
        io.in_valid    = 1'b1;
        tick();
        io.in_valid    = 1'b0;
        io.codeword_in = $urandom;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_lat"}, {31'd0, io.out_valid}, 32'd0);
            if (i == 2) begin
                if (cnt_clr) begin
                    exp_corr   = 0;
                    exp_uncorr = 0;
                end else begin
                    if (es == 2'b01 && exp_corr < 65535)   exp_corr++;
                    if (es == 2'b11 && exp_uncorr < 65535) exp_uncorr++;
                end
            end
            tick();
        end
        chk({tag, "_ovalid"}, {31'd0, io.out_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, io.data_out}, {16'd0, ed});
        chk({tag, "_status"}, {30'd0, io.status}, {30'd0, es});
        chk({tag, "_corr"}, {16'd0, corr_cnt}, exp_corr);
        chk({tag, "_uncorr"}, {16'd0, uncorr_cnt}, exp_uncorr);
        if (io.out_ready) begin
            tick();
            chk({tag, "_odrop"}, {31'd0, io.out_valid}, 32'd0);
            chk({tag, "_idle"}, {31'd0, io.in_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:31] c;
        logic [0:15] d, ed;
        logic [1:0]  es;
        int          p, first, second;

        io.in_valid    = 1'b0;
        io.out_ready   = 1'b1;
        io.codeword_in = '0;
        #1;
        chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_data", {16'd0, io.data_out}, 32'd0);
        chk("rst_status", {30'd0, io.status}, 32'd0);
        chk("rst_corr", {16'd0, corr_cnt}, 32'd0);
        chk("rst_uncorr", {16'd0, uncorr_cnt}, 32'd0);
        #12 rst_n = 1'b1;
        tick();

        // Directed vectors: clean zero, single data error, single check error, 3-bit burst.
        send(32'h0000_0000, "zero");
        chk("zero_status_const", {30'd0, io.status}, 32'd0);
        send(32'h8000_0000, "s00");
        chk("s00_corr_const", {16'd0, corr_cnt}, 32'd1);
        send(32'h0000_0080, "cb00");
        chk("cb00_status_const", {30'd0, io.status}, 32'd2);
        send(32'hE000_0000, "burst");
        chk("burst_status_const", {30'd0, io.status}, 32'd2);

        // Randomized: clean, single data error, single check error, garbage, double error.
        for (int k = 0; k < 40; k++) begin
            d = 16'($urandom);
            c = build(d);
            case ($urandom_range(0, 4))
                0: ;
                1: begin p = $urandom_range(0, 15);  c[p] = ~c[p]; end
                2: begin p = $urandom_range(16, 31); c[p] = ~c[p]; end
                3: c = $urandom;
                default: begin
                    p = $urandom_range(0, 31); c[p] = ~c[p];
                    p = (p + $urandom_range(1, 31)) % 32; c[p] = ~c[p];
                end
            endcase
            send(c, "rand");
        end

        // Consumer stall with a competing codeword offered.
        c = build(16'hA5C3);
        c[6] = ~c[6];
        model(c, ed, es);
        io.out_ready = 1'b0;
        send(c, "stall");
        io.in_valid    = 1'b1;
        io.codeword_in = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_ovalid", {31'd0, io.out_valid}, 32'd1);
            chk("stall_data", {16'd0, io.data_out}, {16'd0, ed});
            chk("stall_status", {30'd0, io.status}, {30'd0, es});
            chk("stall_in_ready", {31'd0, io.in_ready}, 32'd0);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        tick();
        chk("stall_release_ov", {31'd0, io.out_valid}, 32'd0);
        chk("stall_release_rdy", {31'd0, io.in_ready}, 32'd1);
        chk("stall_corr_once", {16'd0, corr_cnt}, exp_corr);

        // Back-to-back with in_valid held high: one result every 5 cycles.
        io.codeword_in = build(16'h0F1E);
        io.in_valid    = 1'b1;
        first  = -1;
        second = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (io.out_valid === 1'b1) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        io.in_valid = 1'b0;
        chk("b2b_first", first, 32'd4);
        chk("b2b_period", second - first, 32'd5);

        // Clear coinciding with a correction: clear wins.
        c = build(16'h3C3C);
        c[9] = ~c[9];
        cnt_clr = 1'b1;
        send(c, "clr_prio");
        cnt_clr = 1'b0;
        send(32'h0000_8000, "after_clr");

        // Reset in the middle of a decode.
        c = build(16'h5555);
        c[3] = ~c[3];
        io.codeword_in = c;
        io.in_valid    = 1'b1;
        tick();
        io.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        exp_corr   = 0;
        exp_uncorr = 0;
        chk("mid_rst_ov", {31'd0, io.out_valid}, 32'd0);
        chk("mid_rst_rdy", {31'd0, io.in_ready}, 32'd1);
        chk("mid_rst_data", {16'd0, io.data_out}, 32'd0);
        chk("mid_rst_corr", {16'd0, corr_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_ov", {31'd0, io.out_valid}, 32'd0);
            chk("post_rst_rdy", {31'd0, io.in_ready}, 32'd1);
        end
        chk("post_rst_corr", {16'd0, corr_cnt}, 32'd0);
        chk("post_rst_uncorr", {16'd0, uncorr_cnt}, 32'd0);
        send(32'h8000_0000, "post_rst_s00");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
